cim_macro_seq: RTL and testbench

//  Parametrised, sequenced behavioural model of the CIM macro for the SNN SoC.
//  - One command latches the word-line spikes and runs the CIM compute phase.
//  - Columns are then converted in groups of ADC_PAR per ADC pass; one done pulse per command.
//  - Replaces separate dac/cim/adc strobes with a single valid/ready handshake; adds abort and saturation.
//  - Sits between the SNN core controller and the analog-macro boundary; results are read via bl_sel/bl_data.

---
 rtl/snn_soc_pkg.sv | 11 +
 rtl/cim_macro_seq_quant.sv | 33 +++
 rtl/cim_macro_seq.sv | 173 +++++++++++++++++
 tb/tb_cim_macro_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_soc_pkg.sv
// Shared SNN SoC defaults and the CIM macro sequencer state type.
package snn_soc_pkg;

  localparam int unsigned NUM_INPUTS         = 49;
  localparam int unsigned NUM_OUTPUTS        = 10;
  localparam int unsigned CIM_LATENCY_CYCLES = 4;
  localparam int unsigned ADC_SAMPLE_CYCLES  = 2;

  typedef enum logic [1:0] {CIM_IDLE, CIM_COMPUTE, CIM_ADC} cim_state_e;

endpackage

// File: rtl/cim_macro_seq_quant.sv
// cim_col_quant: one bit-line column of the CIM model; popcount of the latched
// word lines plus the column offset, clamped to the ADC full-scale code.
module cim_col_quant
  import snn_soc_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = snn_soc_pkg::NUM_INPUTS,
  parameter int unsigned NUM_OUTPUTS = snn_soc_pkg::NUM_OUTPUTS,
  parameter int unsigned ADC_BITS    = 8,
  parameter int unsigned COL_STEP    = 3,
  parameter int unsigned COL_IDX     = 0
) (
  input  logic [NUM_INPUTS-1:0] wl_i,
  output logic [ADC_BITS-1:0]   result_o
);

  // Wide enough for the unclamped sum and for the full-scale constant itself.
  localparam int unsigned SW = $clog2(NUM_INPUTS + 1) + $clog2(NUM_OUTPUTS * COL_STEP + 1) + 1;
  localparam int unsigned CW = (SW > ADC_BITS) ? SW : ADC_BITS + 1;
  localparam logic [CW-1:0] FULL = CW'((64'd1 << ADC_BITS) - 64'd1);

  logic [CW-1:0] pop;
  logic [CW-1:0] sum;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      pop = pop + CW'(wl_i[i]);
    end
    sum      = pop + CW'(COL_IDX * COL_STEP);
    result_o = (sum > FULL) ? FULL[ADC_BITS-1:0] : sum[ADC_BITS-1:0];
  end

endmodule

// File: rtl/cim_macro_seq.sv
// Sequenced CIM macro model: latch spikes, compute phase, grouped ADC passes.
// Optional sticky per-column saturation flags with CIM_MACRO_SAT_FLAG_EN.
module cim_macro_seq
  import snn_soc_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = snn_soc_pkg::NUM_INPUTS,
  parameter int unsigned NUM_OUTPUTS = snn_soc_pkg::NUM_OUTPUTS,
  parameter int unsigned ADC_BITS    = 8,
  parameter int unsigned ADC_PAR     = 4,
  parameter int unsigned CIM_LAT     = snn_soc_pkg::CIM_LATENCY_CYCLES,
  parameter int unsigned ADC_LAT     = snn_soc_pkg::ADC_SAMPLE_CYCLES,
  parameter int unsigned COL_STEP    = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_INPUTS-1:0]          wl_spike,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  output logic                           aborted,
  input  logic [$clog2(NUM_OUTPUTS)-1:0] bl_sel,
  output logic [ADC_BITS-1:0]            bl_data,
  output logic                           bl_sel_err
`ifdef CIM_MACRO_SAT_FLAG_EN
  ,
  output logic [NUM_OUTPUTS-1:0]         sat_flags
`endif
);

  localparam int unsigned NPASS  = (NUM_OUTPUTS + ADC_PAR - 1) / ADC_PAR;
  localparam int unsigned MAXLAT = (CIM_LAT > ADC_LAT) ? CIM_LAT : ADC_LAT;
  localparam int unsigned CNTW   = $clog2(MAXLAT + 1);
  localparam int unsigned PASSW  = $clog2(NPASS + 1);
  localparam int unsigned SELW   = $clog2(NUM_OUTPUTS);

  cim_state_e            state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [PASSW-1:0]      pass_q, pass_d;
  logic [NUM_INPUTS-1:0] wl_q, wl_d;
  logic [ADC_BITS-1:0]   res_q [NUM_OUTPUTS];
  logic [ADC_BITS-1:0]   res_d [NUM_OUTPUTS];
  logic [ADC_BITS-1:0]   col_res [NUM_OUTPUTS];
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
`ifdef CIM_MACRO_SAT_FLAG_EN
  logic [NUM_OUTPUTS-1:0] sat_q, sat_d;
`endif

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_col
    cim_col_quant #(
      .NUM_INPUTS (NUM_INPUTS),
      .NUM_OUTPUTS(NUM_OUTPUTS),
      .ADC_BITS   (ADC_BITS),
      .COL_STEP   (COL_STEP),
      .COL_IDX    (g)
    ) u_quant (
      .wl_i    (wl_q),
      .result_o(col_res[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    wl_d      = wl_q;
    res_d     = res_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
`ifdef CIM_MACRO_SAT_FLAG_EN
    sat_d     = sat_q;
`endif
    case (state_q)
      CIM_IDLE: begin
        if (cmd_valid && !abort) begin
          state_d = CIM_COMPUTE;
          wl_d    = wl_spike;
          cnt_d   = CNTW'(CIM_LAT - 1);
          pass_d  = '0;
`ifdef CIM_MACRO_SAT_FLAG_EN
          sat_d   = '0;
`endif
        end
      end
      CIM_COMPUTE: begin
        if (abort) begin
          state_d   = CIM_IDLE;
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = CIM_ADC;
          pass_d  = '0;
          cnt_d   = CNTW'(ADC_LAT - 1);
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      CIM_ADC: begin
        if (cnt_q == '0) begin
          // The pass write lands even when abort arrives on the same edge.
          for (int unsigned j = 0; j < NUM_OUTPUTS; j++) begin
            if (pass_q == PASSW'(j / ADC_PAR)) begin
              res_d[j] = col_res[j];
`ifdef CIM_MACRO_SAT_FLAG_EN
              if (col_res[j] == '1) sat_d[j] = 1'b1;
`endif
            end
          end
          if (abort) begin
            state_d   = CIM_IDLE;
            aborted_d = 1'b1;
          end else if (pass_q == PASSW'(NPASS - 1)) begin
            state_d = CIM_IDLE;
            done_d  = 1'b1;
          end else begin
            pass_d = pass_q + PASSW'(1);
            cnt_d  = CNTW'(ADC_LAT - 1);
          end
        end else if (abort) begin
          state_d   = CIM_IDLE;
          aborted_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: state_d = CIM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CIM_IDLE;
      cnt_q     <= '0;
      pass_q    <= '0;
      wl_q      <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      for (int unsigned j = 0; j < NUM_OUTPUTS; j++) res_q[j] <= '0;
`ifdef CIM_MACRO_SAT_FLAG_EN
      sat_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      wl_q      <= wl_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      res_q     <= res_d;
`ifdef CIM_MACRO_SAT_FLAG_EN
      sat_q     <= sat_d;
`endif
    end
  end

  assign cmd_ready  = (state_q == CIM_IDLE);
  assign busy       = (state_q != CIM_IDLE);
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign bl_sel_err = (32'(bl_sel) >= NUM_OUTPUTS);
`ifdef CIM_MACRO_SAT_FLAG_EN
  assign sat_flags  = sat_q;
`endif

  always_comb begin
    bl_data = '0;
    for (int unsigned j = 0; j < NUM_OUTPUTS; j++) begin
      if (bl_sel == SELW'(j)) bl_data = res_q[j];
    end
  end

endmodule

// File: tb/tb_cim_macro_seq.sv
// Directed + randomized bench for cim_macro_seq: an 8-bit and a 6-bit ADC
// instance share stimulus and are checked against a spec-level model.
module tb_cim_macro_seq;

  localparam int NI = 49;
  localparam int NO = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] wl_spike = '0;
  logic          cmd_valid = 1'b0;
  logic          abort = 1'b0;
  logic [3:0]    bl_sel = '0;

  logic       rdy_a, busy_a, done_a, ab_a, err_a;
  logic       rdy_b, busy_b, done_b, ab_b, err_b;
  logic [7:0] data_a;
  logic [5:0] data_b;
`ifdef CIM_MACRO_SAT_FLAG_EN
  logic [NO-1:0] sat_a, sat_b;
`endif

  cim_macro_seq #(
    .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .ADC_BITS(8), .ADC_PAR(4),
    .CIM_LAT(4), .ADC_LAT(2), .COL_STEP(3)
  ) dut_a (
    .clk(clk), .rst(rst), .wl_spike(wl_spike), .cmd_valid(cmd_valid),
    .cmd_ready(rdy_a), .abort(abort), .busy(busy_a), .done(done_a),
    .aborted(ab_a), .bl_sel(bl_sel), .bl_data(data_a), .bl_sel_err(err_a)
`ifdef CIM_MACRO_SAT_FLAG_EN
    , .sat_flags(sat_a)
`endif
  );

  cim_macro_seq #(
    .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .ADC_BITS(6), .ADC_PAR(4),
    .CIM_LAT(4), .ADC_LAT(2), .COL_STEP(3)
  ) dut_b (
    .clk(clk), .rst(rst), .wl_spike(wl_spike), .cmd_valid(cmd_valid),
    .cmd_ready(rdy_b), .abort(abort), .busy(busy_b), .done(done_b),
    .aborted(ab_b), .bl_sel(bl_sel), .bl_data(data_b), .bl_sel_err(err_b)
`ifdef CIM_MACRO_SAT_FLAG_EN
    , .sat_flags(sat_b)
`endif
  );

  always #20 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int         exp_a [NO];
  int         exp_b [NO];
  int         tgt_a [NO];
  int         tgt_b [NO];
  logic [NO-1:0] exp_sa = '0;
  logic [NO-1:0] exp_sb = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int full);
    return (v > full) ? full : v;
  endfunction

  // New command: compute the final column values and clear the sticky flags.
  task automatic model_accept(input logic [NI-1:0] s);
    int pop;
    pop = $countones(s);
    for (int j = 0; j < NO; j++) begin
      tgt_a[j] = clamp(pop + 3 * j, 255);
      tgt_b[j] = clamp(pop + 3 * j, 63);
    end
    exp_sa = '0;
    exp_sb = '0;
  endtask

  task automatic model_pass(input int p);
    for (int j = p * 4; j < NO && j < (p + 1) * 4; j++) begin
      exp_a[j] = tgt_a[j];
      exp_b[j] = tgt_b[j];
      if (tgt_a[j] == 255) exp_sa[j] = 1'b1;
      if (tgt_b[j] == 63)  exp_sb[j] = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < NO; j++) begin
      exp_a[j] = 0;
      exp_b[j] = 0;
    end
    exp_sa = '0;
    exp_sb = '0;
  endtask

  task automatic check_ctl(input string tag, input bit rdy, input bit bsy, input bit dn, input bit ab);
    check({tag, "/rdy_a"}, 32'(rdy_a), 32'(rdy));
    check({tag, "/rdy_b"}, 32'(rdy_b), 32'(rdy));
    check({tag, "/busy_a"}, 32'(busy_a), 32'(bsy));
    check({tag, "/busy_b"}, 32'(busy_b), 32'(bsy));
    check({tag, "/done_a"}, 32'(done_a), 32'(dn));
    check({tag, "/done_b"}, 32'(done_b), 32'(dn));
    check({tag, "/aborted_a"}, 32'(ab_a), 32'(ab));
    check({tag, "/aborted_b"}, 32'(ab_b), 32'(ab));
  endtask

  task automatic check_flags(input string tag);
`ifdef CIM_MACRO_SAT_FLAG_EN
    check({tag, "/sat_a"}, 32'(sat_a), 32'(exp_sa));
    check({tag, "/sat_b"}, 32'(sat_b), 32'(exp_sb));
`endif
  endtask

  task automatic read_all(input string tag);
    for (int j = 0; j < NO; j++) begin
      bl_sel = 4'(j);
      #1;
      check($sformatf("%s/res_a[%0d]", tag, j), 32'(data_a), 32'(exp_a[j]));
      check($sformatf("%s/res_b[%0d]", tag, j), 32'(data_b), 32'(exp_b[j]));
      check($sformatf("%s/err[%0d]", tag, j), {30'd0, err_a, err_b}, 32'd0);
    end
    check_flags(tag);
  endtask

  // Steps the edges after an accept; pass p lands at edge 4+2*(p+1).
  task automatic run_phase(input string tag, input int abort_edge, input bit release_at_end);
    int last;
    last = (abort_edge != 0) ? abort_edge : 10;
    for (int n = 1; n <= last; n++) begin
      if (n == abort_edge) abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      if (n >= 6 && (n % 2) == 0) model_pass((n - 4) / 2 - 1);
      if (n == last && release_at_end) cmd_valid = 1'b0;
      check_ctl($sformatf("%s/e%0d", tag, n), n == last, n < last,
                n == 10 && abort_edge == 0, n == abort_edge);
    end
  endtask

  task automatic run_cmd(input logic [NI-1:0] spk, input int abort_edge, input bit hold_valid,
                         input string tag);
    wl_spike  = spk;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    model_accept(spk);
    check_ctl({tag, "/accept"}, 1'b0, 1'b1, 1'b0, 1'b0);
    check_flags({tag, "/accept"});
    if (hold_valid) wl_spike = ~spk;
    else cmd_valid = 1'b0;
    run_phase(tag, abort_edge, 1'b1);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check_ctl({tag, "/after"}, 1'b1, 1'b0, 1'b0, 1'b0);
    read_all(tag);
  endtask

  function automatic logic [NI-1:0] rnd_spk(input bit dense);
    logic [NI-1:0] s;
    s = NI'({$urandom, $urandom});
    if (dense) s = s | NI'({$urandom, $urandom});
    return s;
  endfunction

  initial begin
    logic [NI-1:0] r;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_ctl("rst_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_ctl("rst_rel", 1'b1, 1'b0, 1'b0, 1'b0);
    read_all("rst");

    // All ones: 49..76 unclamped; 6-bit instance saturates columns 5..9
    run_cmd('1, 0, 1'b0, "ones");

    // Randomized commands, alternately holding cmd_valid while busy
    for (int i = 0; i < 6; i++) begin
      run_cmd(rnd_spk(i >= 3), 0, i[0], $sformatf("rnd%0d", i));
    end

    // Back-to-back: zero spikes, then a random vector accepted in the done cycle
    wl_spike  = '0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    model_accept('0);
    r = rnd_spk(1'b1);
    wl_spike = r;
    run_phase("b2b1", 0, 1'b0);
    read_all("b2b1");
    @(posedge clk); #1;
    model_accept(r);
    check_ctl("b2b2/accept", 1'b0, 1'b1, 1'b0, 1'b0);
    check_flags("b2b2/accept");
    cmd_valid = 1'b0;
    run_phase("b2b2", 0, 1'b0);
    @(posedge clk); #1;
    check_ctl("b2b2/after", 1'b1, 1'b0, 1'b0, 1'b0);
    read_all("b2b2");

    // Aborts: during ADC pass 1, on the final pass write, during CIM
    run_cmd(rnd_spk(1'b1), 7, 1'b0, "abort_p1");
    run_cmd(rnd_spk(1'b0), 10, 1'b0, "abort_final");
    run_cmd(rnd_spk(1'b1), 2, 1'b0, "abort_cim");

    // Abort in IDLE blocks the accept
    abort     = 1'b1;
    cmd_valid = 1'b1;
    wl_spike  = '1;
    @(posedge clk); #1;
    check_ctl("abort_idle", 1'b1, 1'b0, 1'b0, 1'b0);
    abort     = 1'b0;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check_ctl("abort_idle2", 1'b1, 1'b0, 1'b0, 1'b0);
    read_all("abort_idle");

    // Reset mid-CIM with cmd_valid held high
    wl_spike  = rnd_spk(1'b1);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    check_ctl("rstmid/accept", 1'b0, 1'b1, 1'b0, 1'b0);
    wl_spike = '1;
    @(posedge clk); #1;
    check_ctl("rstmid/busy", 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    model_reset();
    check_ctl("rstmid/rst", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_ctl("rstmid/idle", 1'b1, 1'b0, 1'b0, 1'b0);
    read_all("rstmid");

    // Out-of-range read selects
    for (int s = 10; s < 16; s++) begin
      bl_sel = 4'(s);
      #1;
      check($sformatf("oor%0d/data_a", s), 32'(data_a), 32'd0);
      check($sformatf("oor%0d/data_b", s), 32'(data_b), 32'd0);
      check($sformatf("oor%0d/err", s), {30'd0, err_a, err_b}, 32'd3);
    end
    bl_sel = 4'd9;
    #1;
    check("sel9/err", {30'd0, err_a, err_b}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
